// File: rtl/mdio_key_cmd_if.sv
// rtl/mdio_key_cmd_if.sv - command/response handshake between key sequencer and MDIO master
interface mdio_key_cmd_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_phy_addr;
   logic [4:0]  cmd_reg_addr;
   logic [15:0] cmd_wr_data;
   logic        rsp_valid;
   logic [15:0] rsp_rd_data;

   modport master (
      output cmd_valid, cmd_op, cmd_phy_addr, cmd_reg_addr, cmd_wr_data,
      input  cmd_ready, rsp_valid, rsp_rd_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_phy_addr, cmd_reg_addr, cmd_wr_data,
      output cmd_ready, rsp_valid, rsp_rd_data
   );
endinterface

// File: rtl/mdio_key_cmd.sv
// rtl/mdio_key_cmd.sv - key-press driven MDIO command sequencer over a fixed 4-entry table
// Optional KEY_QUEUE_EN: one press arriving while busy is held and issued afterwards.
module mdio_key_cmd #(
   parameter logic [4:0]  PHY_ADDR    = 5'd1,
   parameter logic [19:0] TIMEOUT_CYC = 20'd500_000
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   input  logic           key_flag,
   mdio_key_cmd_if.master mdio,
   output logic [15:0]    rd_data,
   output logic [1:0]     cmd_index,
   output logic           busy,
   output logic           done_pulse,
   output logic           timeout_err
);
   localparam logic [1:0] OP_RD = 2'b10;
   localparam logic [1:0] OP_WR = 2'b01;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

   state_t      state_q, state_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [1:0]  cmd_op_q, cmd_op_d;
   logic [4:0]  cmd_phy_q, cmd_phy_d;
   logic [4:0]  cmd_reg_q, cmd_reg_d;
   logic [15:0] cmd_wd_q, cmd_wd_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic [1:0]  cmd_index_q, cmd_index_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        terr_q, terr_d;
   logic [19:0] cnt_q, cnt_d;
   logic        start;

   logic [1:0]  tbl_op;
   logic [4:0]  tbl_reg;
   logic [15:0] tbl_data;

   always_comb begin
      tbl_op   = OP_RD;
      tbl_reg  = 5'h00;
      tbl_data = 16'h0000;
      case (cmd_index_q)
         2'd0:    tbl_reg = 5'h01;
         2'd1:    tbl_reg = 5'h02;
         2'd2:    tbl_reg = 5'h03;
         default: begin
            tbl_op   = OP_WR;
            tbl_reg  = 5'h00;
            tbl_data = 16'h1200;
         end
      endcase
   end

`ifdef KEY_QUEUE_EN
   logic pending_q, pending_d;

   // Pending is consumed the first IDLE cycle; any press outside IDLE (DONE included) arms it.
   always_comb begin
      pending_d = pending_q;
      if (state_q == ST_IDLE)
         pending_d = 1'b0;
      else if (key_flag)
         pending_d = 1'b1;
   end

   assign start = key_flag | pending_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         pending_q <= 1'b0;
      else
         pending_q <= pending_d;
   end
`else
   assign start = key_flag;
`endif

   always_comb begin
      state_d     = state_q;
      cmd_valid_d = cmd_valid_q;
      cmd_op_d    = cmd_op_q;
      cmd_phy_d   = cmd_phy_q;
      cmd_reg_d   = cmd_reg_q;
      cmd_wd_d    = cmd_wd_q;
      rd_data_d   = rd_data_q;
      cmd_index_d = cmd_index_q;
      terr_d      = terr_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_REQ;
               cmd_valid_d = 1'b1;
               cmd_op_d    = tbl_op;
               cmd_phy_d   = PHY_ADDR;
               cmd_reg_d   = tbl_reg;
               cmd_wd_d    = tbl_data;
            end
         end
         ST_REQ: begin
            if (mdio.cmd_ready) begin
               state_d     = ST_WAIT;
               cmd_valid_d = 1'b0;
               cnt_d       = 20'd0;
            end
         end
         ST_WAIT: begin
            // Results land on the WAIT->DONE edge so they are valid alongside done_pulse.
            if (mdio.rsp_valid) begin
               state_d     = ST_DONE;
               done_d      = 1'b1;
               cmd_index_d = cmd_index_q + 2'd1;
               terr_d      = 1'b0;
               if (cmd_op_q == OP_RD)
                  rd_data_d = mdio.rsp_rd_data;
            end else if (cnt_q == TIMEOUT_CYC - 20'd1) begin
               state_d     = ST_DONE;
               done_d      = 1'b1;
               cmd_index_d = cmd_index_q + 2'd1;
               terr_d      = 1'b1;
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= ST_IDLE;
         cmd_valid_q <= 1'b0;
         cmd_op_q    <= 2'b00;
         cmd_phy_q   <= 5'd0;
         cmd_reg_q   <= 5'd0;
         cmd_wd_q    <= 16'h0000;
         rd_data_q   <= 16'h0000;
         cmd_index_q <= 2'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         terr_q      <= 1'b0;
         cnt_q       <= 20'd0;
      end else begin
         state_q     <= state_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_op_q    <= cmd_op_d;
         cmd_phy_q   <= cmd_phy_d;
         cmd_reg_q   <= cmd_reg_d;
         cmd_wd_q    <= cmd_wd_d;
         rd_data_q   <= rd_data_d;
         cmd_index_q <= cmd_index_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         terr_q      <= terr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign mdio.cmd_valid    = cmd_valid_q;
   assign mdio.cmd_op       = cmd_op_q;
   assign mdio.cmd_phy_addr = cmd_phy_q;
   assign mdio.cmd_reg_addr = cmd_reg_q;
   assign mdio.cmd_wr_data  = cmd_wd_q;
   assign rd_data           = rd_data_q;
   assign cmd_index         = cmd_index_q;
   assign busy              = busy_q;
   assign done_pulse        = done_q;
   assign timeout_err       = terr_q;
endmodule
